// File: rtl/seq_div4.sv
// seq_div4: 4-bit unsigned restoring divider producing one quotient bit per CALC cycle.
// A zero divisor skips iteration and reports q=F, r=x with dbz set.
module seq_div4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [3:0] q,
    output logic [3:0] r,
    output logic       busy,
    output logic       done,
    output logic       dbz
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] a_q, a_d;
    logic [3:0] quo_q, quo_d;
    logic [3:0] y_q, y_d;
    logic [2:0] count_q, count_d;
    logic [3:0] q_q, q_d;
    logic [3:0] r_q, r_d;
    logic       dbz_q, dbz_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [4:0] a_sh;
    logic [3:0] quo_sh;
    logic [4:0] t_diff;

    // Next-state, datapath iteration and result-load logic.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        quo_d   = quo_q;
        y_d     = y_q;
        count_d = count_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;

        a_sh   = {a_q[3:0], quo_q[3]};
        quo_sh = {quo_q[2:0], 1'b0};
        // Subtract via inverted divisor plus carry-in; bit 4 flags a negative trial.
        t_diff = a_sh + {1'b1, ~y_q} + 5'd1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (y != 4'd0) begin
                        y_d     = y;
                        a_d     = 5'd0;
                        quo_d   = x;
                        count_d = 3'd4;
                        state_d = CALC;
                    end else begin
                        q_d     = 4'hF;
                        r_d     = x;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                count_d = count_q - 3'd1;
                if (t_diff[4]) begin
                    a_d   = a_sh;
                    quo_d = quo_sh;
                end else begin
                    a_d   = t_diff;
                    quo_d = quo_sh | 4'd1;
                end
                if (count_q == 3'd1) begin
                    q_d     = quo_d;
                    r_d     = a_d[3:0];
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == CALC);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= 5'd0;
            quo_q   <= 4'd0;
            y_q     <= 4'd0;
            count_q <= 3'd0;
            q_q     <= 4'd0;
            r_q     <= 4'd0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            quo_q   <= quo_d;
            y_q     <= y_d;
            count_q <= count_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign q    = q_q;
    assign r    = r_q;
    assign dbz  = dbz_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_seq_div4.sv
// Bench for seq_div4: vector table, exhaustive sweep and multi-cycle corner sequences,
// with expected results queued at start and checked when done pulses.
module tb_seq_div4;
    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] q;
    logic [3:0] r;
    logic       busy;
    logic       done;
    logic       dbz;

    int tests;
    int fails;

    logic [8:0] sb[$];

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] q;
        logic [3:0] r;
        logic       dbz;
    } vec_t;

    vec_t vecs[8];

    seq_div4 dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .x    (x),
        .y    (y),
        .q    (q),
        .r    (r),
        .busy (busy),
        .done (done),
        .dbz  (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Compare the outputs present in a done cycle against the oldest queued expectation.
    task automatic check_result(input string nm);
        logic [8:0] e;
        if (sb.size() == 0) begin
            check({nm, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({nm, "_qrdbz"}, {23'd0, q, r, dbz}, {23'd0, e});
        end
    endtask

    // One full division from IDLE; inputs are scrambled after acceptance.
    task automatic run_div(input logic [3:0] xv, input logic [3:0] yv,
                           input logic [3:0] eq, input logic [3:0] er,
                           input logic edbz, input string nm);
        int lat;
        int busy_cnt;
        x = xv;
        y = yv;
        start = 1'b1;
        sb.push_back({eq, er, edbz});
        tick();
        start = 1'b0;
        x = ~xv;
        y = ~yv;
        lat = 1;
        busy_cnt = 0;
        while (!done && lat < 12) begin
            if (busy) busy_cnt++;
            tick();
            lat++;
        end
        check({nm, "_done_seen"}, 32'(done), 32'd1);
        check({nm, "_latency"}, 32'(lat), (yv == 4'd0) ? 32'd1 : 32'd5);
        check({nm, "_busy_cycles"}, 32'(busy_cnt), (yv == 4'd0) ? 32'd0 : 32'd4);
        check_result(nm);
        tick();
        check({nm, "_done_one_cycle"}, {30'd0, done, busy}, 32'd0);
    endtask

    initial begin
        int lat;
        logic seen;
        logic [3:0] eq;
        logic [3:0] er;
        logic [3:0] hq;
        logic [3:0] hr;

        tests = 0;
        fails = 0;
        vecs[0] = '{x: 4'd13, y: 4'd4,  q: 4'd3,  r: 4'd1, dbz: 1'b0};
        vecs[1] = '{x: 4'd15, y: 4'd1,  q: 4'd15, r: 4'd0, dbz: 1'b0};
        vecs[2] = '{x: 4'd3,  y: 4'd7,  q: 4'd0,  r: 4'd3, dbz: 1'b0};
        vecs[3] = '{x: 4'd9,  y: 4'd0,  q: 4'hF,  r: 4'd9, dbz: 1'b1};
        vecs[4] = '{x: 4'd0,  y: 4'd5,  q: 4'd0,  r: 4'd0, dbz: 1'b0};
        vecs[5] = '{x: 4'd15, y: 4'd15, q: 4'd1,  r: 4'd0, dbz: 1'b0};
        vecs[6] = '{x: 4'd14, y: 4'd3,  q: 4'd4,  r: 4'd2, dbz: 1'b0};
        vecs[7] = '{x: 4'd0,  y: 4'd0,  q: 4'hF,  r: 4'd0, dbz: 1'b1};

        rst = 1'b1;
        start = 1'b1;
        x = 4'd5;
        y = 4'd0;
        tick();
        tick();
        check("reset_outputs", {21'd0, q, r, busy, done, dbz}, 32'd0);
        start = 1'b0;
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_div(vecs[i].x, vecs[i].y, vecs[i].q, vecs[i].r, vecs[i].dbz,
                    $sformatf("vec%0d", i));
        end

        // Results must hold while idle even with new x/y on the inputs.
        run_div(4'd11, 4'd2, 4'd5, 4'd1, 1'b0, "hold_pre");
        hq = q;
        hr = r;
        x = 4'd1;
        y = 4'd1;
        repeat (3) tick();
        check("hold_stable", {24'd0, q, r}, {24'd0, 4'd5, 4'd1});

        // Second start mid-CALC is ignored.
        x = 4'd12;
        y = 4'd5;
        start = 1'b1;
        sb.push_back({4'd2, 4'd2, 1'b0});
        tick();
        start = 1'b0;
        x = 4'd2;
        y = 4'd1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 3;
        while (!done && lat < 12) begin
            tick();
            lat++;
        end
        check("ignore_done_seen", 32'(done), 32'd1);
        check("ignore_latency", 32'(lat), 32'd5);
        check_result("ignore");
        tick();
        run_div(4'd2, 4'd1, 4'd2, 4'd0, 1'b0, "after_ignore");

        // Reset mid-CALC aborts without a done pulse.
        x = 4'd13;
        y = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_outputs", {21'd0, q, r, busy, done, dbz}, 32'd0);
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (done) seen = 1'b1;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        run_div(4'd7, 4'd2, 4'd3, 4'd1, 1'b0, "after_abort");

        for (int xi = 0; xi < 16; xi++) begin
            for (int yi = 0; yi < 16; yi++) begin
                if (yi == 0) begin
                    eq = 4'hF;
                    er = 4'(xi);
                end else begin
                    eq = 4'(xi / yi);
                    er = 4'(xi % yi);
                end
                run_div(4'(xi), 4'(yi), eq, er, (yi == 0),
                        $sformatf("sweep_%0d_%0d", xi, yi));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_div4.md
SEQ_DIV4 -- requirements
Module: seq_div4

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-004 SHALL have port x, input, 4 bits: unsigned dividend.
REQ-005 SHALL have port y, input, 4 bits: unsigned divisor.
REQ-006 SHALL have port q, output, 4 bits: quotient, registered.
REQ-007 SHALL have port r, output, 4 bits: remainder, registered.
REQ-008 SHALL have port busy, output, 1 bit: high while in CALC.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when q/r/dbz update.
REQ-010 SHALL have port dbz, output, 1 bit: divide-by-zero flag for the current result.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, DONE; reset state IDLE.
REQ-012 SHALL, in IDLE with start=1 and y!=0, latch x and y, clear 5-bit partial remainder A to 0, load quotient register Q=x, load count=4, and enter CALC.
REQ-013 SHALL, in IDLE with start=1 and y==0, enter DONE directly without iteration and set q=4'hF, r=x, dbz=1 on that edge.
REQ-014 SHALL, on each CALC edge, shift {A,Q} left by one, then compute T=A-{1'b0,y} as an add of the inverted y with carry-in 1, the same scheme as the team's add/sub path.
REQ-015 SHALL, if T[4]=1 (negative), keep the shifted A and set Q[0]=0; otherwise set A=T and Q[0]=1.
REQ-016 SHALL decrement count on each CALC edge and enter DONE on the edge where count goes 1->0; exactly 4 CALC edges per division.
REQ-017 SHALL, on the edge entering DONE from CALC, load q=Q, r=A[3:0], dbz=0.
REQ-018 SHALL assert done=1 only in DONE, for exactly one cycle, then return to IDLE unconditionally.
REQ-019 SHALL assert busy=1 only in CALC; busy=0 in IDLE and DONE.
REQ-020 SHALL hold q, r, dbz stable from DONE until the next result load; changes to x/y after acceptance SHALL not affect the running division.
REQ-021 SHALL ignore start in CALC and DONE; no queuing, no restart.
REQ-022 SHALL have a latency of 5 edges, start to done, for y!=0: start sampled at edge 0, CALC at edges 1-4, done high in the cycle after edge 4. For y==0 the latency SHALL be 1 edge.
REQ-023 SHALL guarantee the result satisfies x = q*y + r with r < y for all y!=0, including x<y (q=0, r=x) and x=0 (q=0, r=0).

Reset
REQ-024 SHALL, with rst=1 at an edge, enter IDLE and clear q, r, A, Q, count to 0, and busy, done, dbz to 0; rst SHALL take priority over start.
REQ-025 SHALL abort a division in progress on reset mid-CALC or in DONE, with no done pulse for the aborted operation.

Verification
REQ-026 SHALL be covered: x=13, y=4, start one cycle -> busy high 4 cycles, then done pulse with q=3, r=1, dbz=0.
REQ-027 SHALL be covered: x=15, y=1 -> q=15, r=0; and x=3, y=7 -> q=0, r=3.
REQ-028 SHALL be covered: x=9, y=0 -> done one cycle after start, q=4'hF, r=9, dbz=1, busy never high.
REQ-029 SHALL be covered: x=12, y=5 started, then start with x=2, y=1 at CALC cycle 2 -> ignored; result q=2, r=2; a following start in IDLE is accepted.
REQ-030 SHALL be covered: rst asserted at CALC cycle 3 -> next cycle IDLE, all outputs 0, no done pulse; a new division 7/2 afterwards gives q=3, r=1.
REQ-031 SHALL be covered: exhaustive sweep of all 256 (x, y) pairs against reference q/r, with done timing checked per REQ-022.
